// File: rtl/register_status_file.sv
// Architectural register file with per-register rename tags.
// Each register holds a committed 32-bit value and the RoB index of its
// youngest in-flight producer (NON_DEP when none). Two combinational
// operand lookups include a same-cycle commit bypass.
module register_status_file #(
  parameter int                 RoB_WIDTH = 3,
  parameter logic [RoB_WIDTH:0] NON_DEP   = {1'b1, {RoB_WIDTH{1'b0}}}
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 commit_en,
  input  logic [4:0]           commit_reg,
  input  logic [RoB_WIDTH-1:0] commit_index,
  input  logic [31:0]          commit_data,
  input  logic                 rename_en,
  input  logic [4:0]           rename_reg,
  input  logic [RoB_WIDTH-1:0] rename_index,
  input  logic [4:0]           query_rs1,
  output logic [31:0]          rs1_value,
  output logic [RoB_WIDTH:0]   rs1_dep,
  input  logic [4:0]           query_rs2,
  output logic [31:0]          rs2_value,
  output logic [RoB_WIDTH:0]   rs2_dep,
  output logic [31:0]          commit_count
);

  logic [31:0]        r_value [32];
  logic [RoB_WIDTH:0] r_tag   [32];
  logic [31:0]        r_count;

  logic [RoB_WIDTH:0] w_commit_tag;
  logic [RoB_WIDTH:0] w_rename_tag;
  logic               w_commit_act;
  logic               w_commit_clr;
  logic               w_rs1_hit;
  logic               w_rs2_hit;

  assign w_commit_tag = {1'b0, commit_index};
  assign w_rename_tag = {1'b0, rename_index};
  assign w_commit_act = commit_en && rdy_in;
  // A commit only retires the tag if it is still the youngest producer.
  assign w_commit_clr = w_commit_act && (commit_reg != 5'd0) &&
                        (r_tag[commit_reg] == w_commit_tag);
  assign w_rs1_hit    = w_commit_act && (commit_reg == query_rs1) &&
                        (r_tag[query_rs1] == w_commit_tag);
  assign w_rs2_hit    = w_commit_act && (commit_reg == query_rs2) &&
                        (r_tag[query_rs2] == w_commit_tag);

  assign commit_count = r_count;

  // Commit counter and committed values; x0 is never written.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_count <= 32'd0;
      for (int i = 0; i < 32; i++) r_value[i] <= 32'd0;
    end else if (rdy_in && commit_en) begin
      r_count <= r_count + 32'd1;
      if (commit_reg != 5'd0) r_value[commit_reg] <= commit_data;
    end
  end

  // Rename tags: flush clears all, rename overrides a same-cycle commit clear.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) r_tag[i] <= NON_DEP;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < 32; i++) r_tag[i] <= NON_DEP;
      end else begin
        if (w_commit_clr) r_tag[commit_reg] <= NON_DEP;
        if (rename_en && (rename_reg != 5'd0)) r_tag[rename_reg] <= w_rename_tag;
      end
    end
  end

  // Operand 1 lookup with commit bypass.
  always_comb begin
    rs1_value = r_value[query_rs1];
    rs1_dep   = r_tag[query_rs1];
    if (query_rs1 == 5'd0) begin
      rs1_value = 32'd0;
      rs1_dep   = NON_DEP;
    end else if (w_rs1_hit) begin
      rs1_value = commit_data;
      rs1_dep   = NON_DEP;
    end
  end

  // Operand 2 lookup with commit bypass.
  always_comb begin
    rs2_value = r_value[query_rs2];
    rs2_dep   = r_tag[query_rs2];
    if (query_rs2 == 5'd0) begin
      rs2_value = 32'd0;
      rs2_dep   = NON_DEP;
    end else if (w_rs2_hit) begin
      rs2_value = commit_data;
      rs2_dep   = NON_DEP;
    end
  end

endmodule

// File: tb/tb_register_status_file.sv
// Bench for register_status_file: directed scenarios plus randomized traffic
// compared against a behavioural model of the register/tag arrays.
module tb_register_status_file;

  localparam int ND = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        commit_en;
  logic [4:0]  commit_reg;
  logic [2:0]  commit_index;
  logic [31:0] commit_data;
  logic        rename_en;
  logic [4:0]  rename_reg;
  logic [2:0]  rename_index;
  logic [4:0]  query_rs1;
  logic [31:0] rs1_value;
  logic [3:0]  rs1_dep;
  logic [4:0]  query_rs2;
  logic [31:0] rs2_value;
  logic [3:0]  rs2_dep;
  logic [31:0] commit_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_val [32];
  int          m_tag [32];
  logic [31:0] m_cnt;

  always #5 clk_in = ~clk_in;

  register_status_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .commit_en(commit_en), .commit_reg(commit_reg), .commit_index(commit_index),
    .commit_data(commit_data), .rename_en(rename_en), .rename_reg(rename_reg),
    .rename_index(rename_index), .query_rs1(query_rs1), .rs1_value(rs1_value),
    .rs1_dep(rs1_dep), .query_rs2(query_rs2), .rs2_value(rs2_value),
    .rs2_dep(rs2_dep), .commit_count(commit_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 32'd0;
      m_tag[i] = ND;
    end
    m_cnt = 32'd0;
  endtask

  // Expected query result from the architectural rules.
  function automatic logic [31:0] exp_val(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (commit_en && rdy_in && commit_reg == r && m_tag[r] == int'(commit_index))
      return commit_data;
    return m_val[r];
  endfunction

  function automatic logic [31:0] exp_dep(input logic [4:0] r);
    if (r == 5'd0) return ND;
    if (commit_en && rdy_in && commit_reg == r && m_tag[r] == int'(commit_index))
      return ND;
    return m_tag[r];
  endfunction

  task automatic drive(input logic ce, input logic [4:0] cr, input logic [2:0] ci,
                       input logic [31:0] cd, input logic re, input logic [4:0] rr,
                       input logic [2:0] ri, input logic fl);
    rdy_in = 1'b1;
    commit_en = ce; commit_reg = cr; commit_index = ci; commit_data = cd;
    rename_en = re; rename_reg = rr; rename_index = ri; flush_in = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 3'd0, 32'd0, 1'b0, 5'd0, 3'd0, 1'b0);
  endtask

  // Check live outputs against the model, clock once, advance the model.
  task automatic cycle();
    bit clr;
    #2;
    check("rs1_value", rs1_value, exp_val(query_rs1));
    check("rs1_dep", 32'(rs1_dep), exp_dep(query_rs1));
    check("rs2_value", rs2_value, exp_val(query_rs2));
    check("rs2_dep", 32'(rs2_dep), exp_dep(query_rs2));
    check("commit_count", commit_count, m_cnt);
    @(posedge clk_in);
    clr = 1'b0;
    if (rdy_in) begin
      if (commit_en) begin
        m_cnt = m_cnt + 32'd1;
        if (commit_reg != 5'd0) begin
          m_val[commit_reg] = commit_data;
          clr = (m_tag[commit_reg] == int'(commit_index));
        end
      end
      if (flush_in) begin
        for (int i = 0; i < 32; i++) m_tag[i] = ND;
      end else begin
        if (clr) m_tag[commit_reg] = ND;
        if (rename_en && rename_reg != 5'd0) m_tag[rename_reg] = int'(rename_index);
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] base;
    rst_in = 1'b0;
    query_rs1 = 5'd5;
    query_rs2 = 5'd0;
    idle();
    model_reset();
    #12;
    check("reset_count", commit_count, 32'd0);
    check("reset_x5_val", rs1_value, 32'd0);
    check("reset_x5_dep", 32'(rs1_dep), ND);
    @(posedge clk_in); #1;
    rst_in = 1'b1;

    // Rename then commit with matching tag: bypass, then stored.
    query_rs1 = 5'd3; query_rs2 = 5'd3;
    drive(1'b0, 5'd0, 3'd0, 32'd0, 1'b1, 5'd3, 3'd2, 1'b0); cycle();
    drive(1'b1, 5'd3, 3'd2, 32'h1234, 1'b0, 5'd0, 3'd0, 1'b0);
    #1;
    check("bypass_val", rs1_value, 32'h1234);
    check("bypass_dep", 32'(rs1_dep), ND);
    cycle();
    idle(); #1;
    check("x3_val", rs1_value, 32'h1234);
    check("x3_dep", 32'(rs1_dep), ND);
    check("count_one", commit_count, 32'd1);

    // Stale commit: younger producer keeps the tag, no bypass.
    query_rs1 = 5'd4;
    drive(1'b0, 5'd0, 3'd0, 32'd0, 1'b1, 5'd4, 3'd1, 1'b0); cycle();
    drive(1'b0, 5'd0, 3'd0, 32'd0, 1'b1, 5'd4, 3'd5, 1'b0); cycle();
    drive(1'b1, 5'd4, 3'd1, 32'd9, 1'b0, 5'd0, 3'd0, 1'b0);
    #1;
    check("stale_nobypass_val", rs1_value, 32'd0);
    check("stale_nobypass_dep", 32'(rs1_dep), 32'd5);
    cycle();
    idle(); #1;
    check("stale_val", rs1_value, 32'd9);
    check("stale_dep", 32'(rs1_dep), 32'd5);

    // Commit and rename on the same register in the same cycle.
    query_rs1 = 5'd6;
    drive(1'b0, 5'd0, 3'd0, 32'd0, 1'b1, 5'd6, 3'd0, 1'b0); cycle();
    drive(1'b1, 5'd6, 3'd0, 32'hAA, 1'b1, 5'd6, 3'd3, 1'b0); cycle();
    idle(); #1;
    check("x6_val", rs1_value, 32'hAA);
    check("x6_dep", 32'(rs1_dep), 32'd3);

    // Flush with a same-cycle commit and rename.
    drive(1'b0, 5'd0, 3'd0, 32'd0, 1'b1, 5'd1, 3'd1, 1'b0); cycle();
    drive(1'b0, 5'd0, 3'd0, 32'd0, 1'b1, 5'd2, 3'd2, 1'b0); cycle();
    drive(1'b0, 5'd0, 3'd0, 32'd0, 1'b1, 5'd31, 3'd7, 1'b0); cycle();
    base = commit_count;
    drive(1'b1, 5'd7, 3'd6, 32'h55, 1'b1, 5'd8, 3'd4, 1'b1); cycle();
    idle();
    query_rs1 = 5'd1; query_rs2 = 5'd2; #1;
    check("flush_x1_dep", 32'(rs1_dep), ND);
    check("flush_x2_dep", 32'(rs2_dep), ND);
    query_rs1 = 5'd31; query_rs2 = 5'd8; #1;
    check("flush_x31_dep", 32'(rs1_dep), ND);
    check("flush_x8_dep", 32'(rs2_dep), ND);
    query_rs1 = 5'd7; #1;
    check("flush_x7_val", rs1_value, 32'h55);
    check("flush_count", commit_count, base + 32'd1);

    // x0 is immutable but commits to it still count; pause holds everything.
    query_rs1 = 5'd0; query_rs2 = 5'd9;
    base = commit_count;
    drive(1'b1, 5'd0, 3'd2, 32'hFF, 1'b1, 5'd0, 3'd2, 1'b0); cycle();
    idle(); #1;
    check("x0_val", rs1_value, 32'd0);
    check("x0_dep", 32'(rs1_dep), ND);
    check("x0_count", commit_count, base + 32'd1);
    drive(1'b1, 5'd9, 3'd0, 32'd3, 1'b1, 5'd9, 3'd1, 1'b1);
    rdy_in = 1'b0;
    cycle();
    idle(); #1;
    check("pause_x9_val", rs2_value, 32'd0);
    check("pause_x9_dep", 32'(rs2_dep), ND);
    check("pause_count", commit_count, base + 32'd1);

    // Randomized traffic, biased to a few registers and to live tags.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] cr;
      logic [2:0] ci;
      cr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      ci = 3'($urandom);
      if (m_tag[cr] != ND && $urandom_range(0, 1) == 1) ci = 3'(m_tag[cr]);
      drive(1'($urandom_range(0, 1)), cr, ci, $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), 3'($urandom),
            ($urandom_range(0, 15) == 0));
      rdy_in = ($urandom_range(0, 7) != 0);
      query_rs1 = ($urandom_range(0, 1) == 1) ? cr : 5'($urandom_range(0, 9));
      query_rs2 = 5'($urandom);
      cycle();
    end

    // Asynchronous reset in the middle of a run.
    query_rs1 = 5'd5;
    drive(1'b1, 5'd5, 3'd0, 32'd7, 1'b0, 5'd0, 3'd0, 1'b1); cycle();
    idle(); #1;
    check("x5_before_reset", rs1_value, 32'd7);
    rst_in = 1'b0;
    #1;
    check("async_x5_val", rs1_value, 32'd0);
    check("async_x5_dep", 32'(rs1_dep), ND);
    check("async_count", commit_count, 32'd0);
    model_reset();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    for (int n = 0; n < 4; n++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
